// File: rtl/cache_pkg.sv
// Constants and state type shared by the line-fill controller and the cache
// data/tag arrays.
package cache_pkg;

    localparam int LINE_WORDS = 8;
    localparam int WORD_IDX_W = $clog2(LINE_WORDS);
    localparam int OFFSET_W   = WORD_IDX_W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_t;

endpackage

// File: rtl/fill_counter.sv
// Up-counter with synchronous clear and enable. It is one bit wider than a
// word index, so the MSB flags that a whole line has been counted.
module fill_counter #(
    parameter int W = cache_pkg::WORD_IDX_W + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= count_reg + W'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss line-fill controller: issues one read per word of the missing
// line, streams returned words into the data array, and writes the tag last.
module cache_fill_fsm #(
    parameter int LINE_WORDS = cache_pkg::LINE_WORDS,
    parameter int ADDR_W     = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          miss_detected,
    input  logic [ADDR_W-1:0]             miss_address,
    input  logic                          memory_data_valid,
    input  logic [15:0]                   memory_data,
    output logic                          fsm_busy,
    output logic                          mem_en,
    output logic [ADDR_W-1:0]             memory_address,
    output logic                          write_data_array,
    output logic                          write_tag_array,
    output logic [$clog2(LINE_WORDS)-1:0] fill_word,
    output logic [15:0]                   fill_data,
    output logic                          fill_done
);

    import cache_pkg::fill_state_t;
    import cache_pkg::IDLE;
    import cache_pkg::FILL;

    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam int OFF_W = IDX_W + 1;
    localparam logic [ADDR_W-1:0] TAG_MASK = {{(ADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};
    localparam logic [IDX_W:0]    LAST_IDX = (IDX_W+1)'(LINE_WORDS - 1);

    fill_state_t       state_reg;
    logic [ADDR_W-1:0] base_reg;

    logic              start_fill;
    logic              issue_active;
    logic              recv_fire;
    logic              last_recv;
    logic [1:0]        cnt_en;
    logic [IDX_W:0]    cnt [2];
    logic [IDX_W:0]    issue_cnt;
    logic [IDX_W:0]    recv_cnt;

    assign start_fill   = (state_reg == IDLE) && miss_detected;
    assign issue_active = (state_reg == FILL) && !issue_cnt[IDX_W];
    assign recv_fire    = (state_reg == FILL) && memory_data_valid;
    assign last_recv    = recv_fire && (recv_cnt == LAST_IDX);

    assign cnt_en    = {recv_fire, issue_active};
    assign issue_cnt = cnt[0];
    assign recv_cnt  = cnt[1];

    // Index 0 counts issued reads, index 1 counts returned words.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            fill_counter #(.W(IDX_W + 1)) u_cnt (
                .clk   (clk),
                .rst_n (rst_n),
                .clr   (start_fill),
                .en    (cnt_en[gi]),
                .count (cnt[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            base_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (miss_detected) begin
                        base_reg  <= miss_address & TAG_MASK;
                        state_reg <= FILL;
                    end
                end
                FILL: begin
                    if (last_recv) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // The offset bits of base_reg are always zero, so OR-ing the word offset
    // in is a pure concatenation and can never carry into the tag.
    assign memory_address   = issue_active
                              ? (base_reg | ADDR_W'({issue_cnt[IDX_W-1:0], 1'b0}))
                              : '0;
    assign mem_en           = issue_active;
    assign fsm_busy         = (state_reg == FILL);
    assign write_data_array = recv_fire;
    assign fill_word        = recv_fire ? recv_cnt[IDX_W-1:0] : '0;
    assign fill_data        = memory_data;
    assign write_tag_array  = last_recv;
    assign fill_done        = last_recv;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm: a reset/spurious-input vector
// table, directed fill scenarios, and randomized fills against a line model.
module tb_cache_fill_fsm;

    localparam int LW = 8;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          miss_detected = 1'b0;
    logic [AW-1:0] miss_address = '0;
    logic          memory_data_valid = 1'b0;
    logic [15:0]   memory_data = '0;
    logic          fsm_busy;
    logic          mem_en;
    logic [AW-1:0] memory_address;
    logic          write_data_array;
    logic          write_tag_array;
    logic [2:0]    fill_word;
    logic [15:0]   fill_data;
    logic          fill_done;

    always #5 clk = ~clk;

    cache_fill_fsm #(.LINE_WORDS(LW), .ADDR_W(AW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data_valid (memory_data_valid),
        .memory_data       (memory_data),
        .fsm_busy          (fsm_busy),
        .mem_en            (mem_en),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .write_tag_array   (write_tag_array),
        .fill_word         (fill_word),
        .fill_data         (fill_data),
        .fill_done         (fill_done)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    // Line model: a fill is busy until LW words have been returned.
    bit m_busy = 1'b0;
    int m_base = 0;
    int m_issued = 0;
    int m_recv = 0;

    // Memory model: fixed latency, in-order returns, optional gap.
    typedef struct {
        logic [15:0] addr;
        int          due;
    } req_t;
    req_t mq[$];
    int lat = 4;
    int gap_after = -1;
    int gap_len = 0;
    int stall = 0;
    int delivered = 0;
    bit rand_miss = 1'b0;

    logic [15:0] issued_log[$];
    int          issue_cyc_log[$];
    int          word_log[$];
    int          start_cyc = 0;
    int          done_cyc = 0;
    int          first_wr_cyc = -1;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'hA5A5;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        bit          e_en;
        bit          e_wr;
        bit          e_done;
        logic [15:0] e_addr;
        @(negedge clk);
        e_en   = m_busy && (m_issued < LW);
        e_addr = e_en ? 16'(m_base + 2 * m_issued) : 16'h0;
        e_wr   = m_busy && memory_data_valid;
        e_done = e_wr && (m_recv == LW - 1);
        chk("fsm_busy", 32'(fsm_busy), 32'(m_busy));
        chk("mem_en", 32'(mem_en), 32'(e_en));
        chk("memory_address", 32'(memory_address), 32'(e_addr));
        chk("write_data_array", 32'(write_data_array), 32'(e_wr));
        chk("write_tag_array", 32'(write_tag_array), 32'(e_done));
        chk("fill_done", 32'(fill_done), 32'(e_done));
        if (e_wr) begin
            chk("fill_word", 32'(fill_word), 32'(m_recv));
            chk("fill_data", 32'(fill_data), 32'(mem_word(16'(m_base + 2 * m_recv))));
            word_log.push_back(int'(fill_word));
            if (first_wr_cyc < 0) first_wr_cyc = cyc;
        end
        if (mem_en) begin
            mq.push_back('{memory_address, cyc + lat});
            issued_log.push_back(memory_address);
            issue_cyc_log.push_back(cyc);
        end
        if (e_done) done_cyc = cyc;
        if (!rst_n) begin
            m_busy = 1'b0; m_base = 0; m_issued = 0; m_recv = 0;
        end else if (!m_busy) begin
            if (miss_detected) begin
                m_busy = 1'b1;
                m_base = int'(miss_address) & 32'hFFF0;
                m_issued = 0;
                m_recv = 0;
                start_cyc = cyc;
            end
        end else begin
            if (e_en) m_issued++;
            if (e_wr) m_recv++;
            if (e_done) m_busy = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
        memory_data_valid = 1'b0;
        memory_data = 16'($urandom);
        if (stall > 0) begin
            stall--;
        end else if (mq.size() > 0 && mq[0].due <= cyc) begin
            memory_data_valid = 1'b1;
            memory_data = mem_word(mq[0].addr);
            void'(mq.pop_front());
            delivered++;
            if (delivered == gap_after) stall = gap_len;
        end
        if (rand_miss) begin
            miss_detected = ($urandom_range(0, 3) == 0);
            miss_address = 16'($urandom);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (m_busy && n < budget) begin
            tick();
            n++;
        end
        chk("fill_timeout", 32'(n < budget), 32'd1);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (mq.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        chk("drain_timeout", 32'(n < budget), 32'd1);
    endtask

    task automatic clear_logs();
        issued_log.delete();
        issue_cyc_log.delete();
        word_log.delete();
        first_wr_cyc = -1;
        delivered = 0;
        stall = 0;
    endtask

    task automatic do_fill(input logic [15:0] addr, input int l);
        lat = l;
        clear_logs();
        miss_detected = 1'b1;
        miss_address = addr;
        tick();
        miss_detected = 1'b0;
        wait_idle(300);
        tick();
    endtask

    typedef struct {
        logic        rst_n;
        logic        miss;
        logic [15:0] addr;
        logic        valid;
        logic [15:0] data;
        logic        e_busy;
        logic        e_en;
        logic [15:0] e_addr;
        logic        e_wr;
        logic        e_done;
    } vec_t;

    vec_t vecs[11];

    initial begin
        // Reset, spurious valid in IDLE, second miss in FILL, reset mid-fill.
        vecs[0]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'hBEEF, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'hBEEF, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 16'h1236, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 16'h4000, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h1230, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h1232, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h1234, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h1236, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'hBEEF, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h1234, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};

        for (int i = 0; i < 11; i++) begin
            rst_n = vecs[i].rst_n;
            miss_detected = vecs[i].miss;
            miss_address = vecs[i].addr;
            memory_data_valid = vecs[i].valid;
            memory_data = vecs[i].data;
            @(negedge clk);
            chk($sformatf("vec%0d_busy", i), 32'(fsm_busy), 32'(vecs[i].e_busy));
            chk($sformatf("vec%0d_mem_en", i), 32'(mem_en), 32'(vecs[i].e_en));
            chk($sformatf("vec%0d_addr", i), 32'(memory_address), 32'(vecs[i].e_addr));
            chk($sformatf("vec%0d_wr", i), 32'(write_data_array), 32'(vecs[i].e_wr));
            chk($sformatf("vec%0d_done", i), 32'(fill_done | write_tag_array), 32'(vecs[i].e_done));
            chk($sformatf("vec%0d_word", i), 32'(fill_word), 32'd0);
            chk($sformatf("vec%0d_data", i), 32'(fill_data), 32'(vecs[i].data));
            @(posedge clk);
            #1;
        end
        $display("[TB] vector table done");

        memory_data_valid = 1'b0;
        miss_detected = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Basic fill, L=4.
        do_fill(16'h1236, 4);
        chk("basic_issue_count", 32'(issued_log.size()), 32'd8);
        for (int i = 0; i < issued_log.size() && i < 8; i++)
            chk($sformatf("basic_addr%0d", i), 32'(issued_log[i]), 32'h1230 + 32'(2 * i));
        chk("basic_first_issue_cyc", 32'(issue_cyc_log[0] - start_cyc), 32'd1);
        chk("basic_first_write_cyc", 32'(first_wr_cyc - start_cyc), 32'd5);
        chk("basic_done_cyc", 32'(done_cyc - start_cyc), 32'd12);
        $display("[TB] basic fill: start %0d done %0d", start_cyc, done_cyc);

        // Top of memory: no wrap into the tag.
        do_fill(16'hFFFF, 2);
        chk("top_first_addr", 32'(issued_log[0]), 32'hFFF0);
        chk("top_last_addr", 32'(issued_log[issued_log.size() - 1]), 32'hFFFE);
        $display("[TB] top-of-memory fill: %0d issues", issued_log.size());

        // 3-cycle gap after word 3.
        gap_after = 4;
        gap_len = 3;
        do_fill(16'h0A10, 3);
        chk("gap_words", 32'(word_log.size()), 32'd8);
        for (int i = 0; i < word_log.size() && i < 8; i++)
            chk($sformatf("gap_word%0d", i), 32'(word_log[i]), 32'(i));
        chk("gap_done_cyc", 32'(done_cyc - start_cyc), 32'd14);
        gap_after = -1;
        gap_len = 0;
        $display("[TB] gapped fill: done after %0d cycles", done_cyc - start_cyc);

        // Reset in cycle 6 of a fill; leftover returns must be ignored.
        lat = 4;
        clear_logs();
        miss_detected = 1'b1;
        miss_address = 16'h0300;
        tick();
        miss_detected = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_busy_cleared", 32'(fsm_busy), 32'd0);
        drain(100);
        do_fill(16'h0040, 4);
        chk("post_rst_first_addr", 32'(issued_log[0]), 32'h0040);
        chk("post_rst_last_addr", 32'(issued_log[issued_log.size() - 1]), 32'h004E);
        $display("[TB] reset mid-fill then refill at 0x0040");

        // Miss held through fill_done with a new address.
        lat = 4;
        clear_logs();
        miss_detected = 1'b1;
        miss_address = 16'h5554;
        tick();
        miss_address = 16'h2000;
        wait_idle(300);
        begin
            int d1;
            d1 = done_cyc;
            tick();
            miss_detected = 1'b0;
            wait_idle(300);
            tick();
            chk("b2b_issue_count", 32'(issued_log.size()), 32'd16);
            chk("b2b_first_addr", 32'(issued_log[0]), 32'h5550);
            chk("b2b_second_addr", 32'(issued_log[8]), 32'h2000);
            chk("b2b_second_last", 32'(issued_log[15]), 32'h200E);
            chk("b2b_restart_gap", 32'(issue_cyc_log[8] - d1), 32'd2);
            $display("[TB] back-to-back: first done %0d, second issues at %0d", d1, issue_cyc_log[8]);
        end

        // Random fills with random latency, gaps and stray misses.
        for (int r = 0; r < 20; r++) begin
            lat = $urandom_range(1, 8);
            clear_logs();
            gap_after = $urandom_range(1, 8);
            gap_len = $urandom_range(0, 4);
            miss_detected = 1'b1;
            miss_address = 16'($urandom);
            tick();
            rand_miss = 1'b1;
            repeat (10) tick();
            rand_miss = 1'b0;
            miss_detected = 1'b0;
            wait_idle(500);
            drain(100);
            wait_idle(500);
            $display("[TB] random fill %0d: lat %0d gap %0d/%0d", r, lat, gap_after, gap_len);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cache_fill_fsm.md
# cache_fill_fsm

Miss-handling controller that sits downstream of the single-cycle core's memory-access logic, between the cache lookup and multi-cycle main memory. On a miss it fetches the full 8-word line containing the missing address. Fetch addresses are issued one word per cycle, and returned words are streamed into the cache data array. The tag array is written with the last word. While it runs, the core stalls on `fsm_busy`.

## Interface
Parameters:
- `LINE_WORDS`, default 8: 16-bit words per cache line; must be a power of two.
- `ADDR_W`, default 16: byte-address width.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `miss_detected` in 1: cache lookup missed this cycle.
- `miss_address` in `ADDR_W`: byte address of the missing access.
- `memory_data_valid` in 1: main memory returns a word this cycle.
- `memory_data` in 16: returned word.
- `fsm_busy` out 1: fill in progress; core stalls.
- `mem_en` out 1: issue a read to main memory this cycle.
- `memory_address` out `ADDR_W`: read address; 0 when `mem_en` is low.
- `write_data_array` out 1: write `fill_data` into word `fill_word` of the line.
- `write_tag_array` out 1: write tag and valid for the line.
- `fill_word` out log2(`LINE_WORDS`): word index within the line being written.
- `fill_data` out 16: data to the cache data array.
- `fill_done` out 1: single-cycle pulse when the line is complete.

## Operation
- OFFSET_W = log2(`LINE_WORDS`) + 1, which is 4 for the default.
- States: IDLE, FILL.
- IDLE:
  - When `miss_detected` = 1, latch `base = {miss_address[ADDR_W-1:OFFSET_W], OFFSET_W'b0}`, clear `issue_cnt` and `recv_cnt`, and go to FILL.
  - `memory_data_valid` is ignored in IDLE.
- FILL, issue side:
  - While `issue_cnt` < `LINE_WORDS`: `mem_en` = 1, `memory_address = {base[ADDR_W-1:OFFSET_W], issue_cnt, 1'b0}`, and `issue_cnt` increments.
  - After `LINE_WORDS` issues, `mem_en` = 0.
  - The word offset is concatenated, never added, so addresses cannot carry into the tag bits. Base 0xFFF0 issues 0xFFF0 through 0xFFFE.
- FILL, receive side:
  - On `memory_data_valid`: `write_data_array` = 1, `fill_word` = `recv_cnt`, `fill_data` = `memory_data` (combinational pass-through), and `recv_cnt` increments.
  - Receives may overlap issues.
- Completion: on the valid with `recv_cnt` = `LINE_WORDS`-1, in the same cycle:
  - `write_tag_array` = 1 and `fill_done` = 1;
  - the next state is IDLE.
- `fsm_busy` = (state == FILL).
- `miss_detected` during FILL is ignored, including in the `fill_done` cycle. A miss still held the following cycle starts a new fill.
- Reset asserted mid-fill: next edge forces IDLE and clears both counters and `base`. Words returned afterwards from in-flight requests are ignored because the block is in IDLE.

## Timing
- Reset values:
  - state IDLE, `base` 0, counters 0;
  - all 1-bit outputs 0, `memory_address` 0, `fill_word` 0;
  - `fill_data` follows `memory_data`, but is qualified by `write_data_array`.
- Miss sampled at edge 0:
  - `fsm_busy` and the first `mem_en` (word 0) appear in cycle 1;
  - issues occupy cycles 1–8;
  - with memory latency L, data arrives in cycles 1+L through 8+L;
  - `fill_done` asserts in cycle 8+L;
  - `fsm_busy` drops in cycle 9+L.
- For L = 4: busy for cycles 1–12, `fill_done` in cycle 12, and the core resumes in cycle 13.
- The block places no requirement on L. Completion is counted by valids, not by time.

## Structure
- Shared package `cache_pkg`:
  - state enum `fill_state_t` {IDLE, FILL};
  - `LINE_WORDS`, `OFFSET_W`, `WORD_IDX_W` constants, reused by the cache data and tag arrays.
- One sub-module, `fill_counter`: a `WORD_IDX_W`+1-bit up-counter with synchronous clear and enable. It is instantiated twice, once for issue and once for receive; the extra bit marks terminal count.
- The top level holds the state register, the `base` register, and the output decode.

## Test plan
- Basic fill, L=4, miss at 0x1236 → `mem_en` for cycles 1–8 at 0x1230, 0x1232 … 0x123E; writes to words 0–7 in cycles 5–12; `write_tag_array` and `fill_done` in cycle 12; `fsm_busy` low in cycle 13.
- Top of memory, miss at 0xFFFF → addresses 0xFFF0 … 0xFFFE, with no wrap to 0x0000.
- Irregular valids: the memory model inserts a 3-cycle gap after word 3 → `fill_word` sequence is still 0–7 in order, and `fill_done` comes only with the 8th valid.
- Spurious input: `memory_data_valid` = 1 in IDLE with data 0xBEEF → no array writes and no state change; a 2nd `miss_detected` during FILL → no re-latch of `base`.
- Reset mid-fill: `rst_n` low in cycle 6 for one cycle → IDLE with all outputs 0; the remaining valids cause no writes; a new miss at 0x0040 then fills 0x0040–0x004E normally.
- Back-to-back misses: `miss_detected` held through the `fill_done` cycle with a new address 0x2000 → the second fill starts issuing in the cycle after `fsm_busy` drops.
